// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation sequencer: FSM state encoding
// and the JK excitation table (present/next bit -> {j,k}).
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;

  // Inverse of the JK characteristic equation; don't-cares resolved to 0 so
  // the toggle case (j=k=1) is never requested.
  function automatic logic [1:0] jk_excite(input logic q_bit, input logic next_bit);
    logic [1:0] jk;
    case ({q_bit, next_bit})
      2'b01:   jk = 2'b10;
      2'b10:   jk = 2'b01;
      default: jk = JK_HOLD;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops with async active-low reset.
// Each bit implements hold / reset / set / toggle from its own j,k pair.
module jk_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ff
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg[gi] <= 1'b0;
        end else begin
          case ({j[gi], k[gi]})
            2'b01:   q_reg[gi] <= 1'b0;
            2'b10:   q_reg[gi] <= 1'b1;
            2'b11:   q_reg[gi] <= ~q_reg[gi];
            default: q_reg[gi] <= q_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Moves a JK flip-flop bank to a requested target, either in one jump or by
// +/-1 steps, deriving j/k from the excitation table each cycle.
module jk_excitation_sequencer
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_value,
  input  logic             tgt_step,
  input  logic             abort,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] j_calc, k_calc;
  logic             accept;

  assign accept = tgt_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tgt_reg  <= tgt_value;
        mode_reg <= tgt_step;
      end
    end
  end

  // Step mode saturates naturally: it only moves toward the target, never wraps.
  always_comb begin
    next_q = q;
    if (!mode_reg) begin
      next_q = tgt_reg;
    end else if (tgt_reg > q) begin
      next_q = q + 1'b1;
    end else if (tgt_reg < q) begin
      next_q = q - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
      assign {j_calc[gi], k_calc[gi]} = jk_excite(q[gi], next_q[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (tgt_value == q) ? DONE : STEP;
        end
      end
      STEP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (next_q == tgt_reg) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state_reg == IDLE);
    busy      = (state_reg == STEP) || (state_reg == DONE);
    done      = (state_reg == DONE);
    j_out     = '0;
    k_out     = '0;
    if ((state_reg == STEP) && !abort) begin
      j_out = j_calc;
      k_out = k_calc;
    end
  end

  jk_ff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j_out),
    .k    (k_out),
    .q    (q),
    .qbar (qbar)
  );

  a_qbar_complement : assert property (@(posedge clk) qbar == ~q);

endmodule
